// File: rtl/pic_pkg.sv
// Shared types and encodings for the 8259A ICW/OCW command sequencer.
// Holds the sequencer state enum, ICW4 field positions and OCW2 command codes.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } seq_state_t;

  // Bit positions inside icw4_cfg = {SFNM,BUF,M/S,AEOI,uPM}
  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  // OCW2 {R,SL,EOI} command encodings
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  localparam logic [7:0] CASCADE_RST = 8'h07;

  function automatic logic is_icw1(input logic a0, input logic [7:0] d);
    return !a0 && d[4];
  endfunction

endpackage

// File: rtl/pic_write_capture.sv
// CPU write capture: latches A0/data while the strobe is low, commit strobe on the edge after it rises.
// No backpressure; a write held across reset release never commits.
module pic_write_capture (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       chip_select_bar,
  input  logic       write_bar,
  input  logic       A0,
  input  logic [7:0] data_in,
  output logic       commit,
  output logic       cap_a0,
  output logic [7:0] cap_data
);

  logic wr;
  logic wr_q;
  logic armed;

  assign wr     = ~write_bar & ~chip_select_bar;
  assign commit = wr_q & ~wr;

  // armed stays low until the bus has been seen idle after reset
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_q     <= 1'b0;
      armed    <= 1'b0;
      cap_a0   <= 1'b0;
      cap_data <= 8'h00;
    end else begin
      armed <= armed | ~wr;
      wr_q  <= wr & armed;
      if (wr) begin
        cap_a0   <= A0;
        cap_data <= data_in;
      end
    end
  end

endmodule

// File: rtl/icw_ocw_sequencer.sv
// 8259A ICW1-4 init sequencer and OCW1-3 decoder; registers update on the commit edge, pulses follow it by one cycle.
// No backpressure. Optional sticky seq_error output when SEQ_ERR_EN is defined.
module icw_ocw_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] IMR_INIT     = 8'h00,
  parameter logic [4:0] ICW4_DEFAULT = 5'h00
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       chip_select_bar,
  input  logic       write_bar,
  input  logic       A0,
  input  logic [7:0] data_in,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       level_trig,
  output logic       single_mode,
  output logic [7:0] cascade_cfg,
  output logic [4:0] icw4_cfg,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr_sel,
  output logic       special_mask,
  output logic       poll_req
`ifdef SEQ_ERR_EN
  ,
  output logic       seq_error
`endif
);

  logic       commit;
  logic       cap_a0;
  logic [7:0] cap_data;

  seq_state_t state_q, state_d;
  logic       ic4_q;
  logic       ld_icw1, ld_icw2, ld_icw3, ld_icw4, ld_def;
  logic       ld_ocw1, ld_ocw2, ld_ocw3;

  pic_write_capture u_cap (
    .clk             (clk),
    .reset_bar       (reset_bar),
    .chip_select_bar (chip_select_bar),
    .write_bar       (write_bar),
    .A0              (A0),
    .data_in         (data_in),
    .commit          (commit),
    .cap_a0          (cap_a0),
    .cap_data        (cap_data)
  );

  assign init_done = (state_q == READY);

  always_comb begin
    state_d = state_q;
    ld_icw1 = 1'b0;
    ld_icw2 = 1'b0;
    ld_icw3 = 1'b0;
    ld_icw4 = 1'b0;
    ld_def  = 1'b0;
    ld_ocw1 = 1'b0;
    ld_ocw2 = 1'b0;
    ld_ocw3 = 1'b0;
    if (commit) begin
      if (is_icw1(cap_a0, cap_data)) begin
        ld_icw1 = 1'b1;
        state_d = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (cap_a0) begin
            ld_icw2 = 1'b1;
            if (!single_mode)  state_d = WAIT_ICW3;
            else if (ic4_q)    state_d = WAIT_ICW4;
            else begin
              state_d = READY;
              ld_def  = 1'b1;
            end
          end
          WAIT_ICW3: if (cap_a0) begin
            ld_icw3 = 1'b1;
            state_d = ic4_q ? WAIT_ICW4 : READY;
            ld_def  = ~ic4_q;
          end
          WAIT_ICW4: if (cap_a0) begin
            ld_icw4 = 1'b1;
            state_d = READY;
          end
          READY: begin
            if (cap_a0)           ld_ocw1 = 1'b1;
            else if (!cap_data[3]) ld_ocw2 = 1'b1;
            else                  ld_ocw3 = 1'b1;
          end
          UNINIT:  state_d = UNINIT;
          default: state_d = UNINIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q      <= UNINIT;
      ic4_q        <= 1'b0;
      vector_base  <= 5'h00;
      level_trig   <= 1'b0;
      single_mode  <= 1'b0;
      cascade_cfg  <= CASCADE_RST;
      icw4_cfg     <= 5'h00;
      imr          <= IMR_INIT;
      ocw2_valid   <= 1'b0;
      ocw2_cmd     <= 3'b000;
      ocw2_level   <= 3'b000;
      read_isr_sel <= 1'b0;
      special_mask <= 1'b0;
      poll_req     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ocw2_valid <= ld_ocw2;
      poll_req   <= ld_ocw3 & cap_data[2];
      if (ld_icw1) begin
        level_trig   <= cap_data[3];
        single_mode  <= cap_data[1];
        ic4_q        <= cap_data[0];
        imr          <= IMR_INIT;
        read_isr_sel <= 1'b0;
        special_mask <= 1'b0;
        cascade_cfg  <= CASCADE_RST;
        icw4_cfg     <= 5'h00;
      end
      if (ld_icw2) vector_base <= cap_data[7:3];
      if (ld_icw3) cascade_cfg <= cap_data;
      if (ld_icw4) icw4_cfg    <= cap_data[4:0];
      if (ld_def)  icw4_cfg    <= ICW4_DEFAULT;
      if (ld_ocw1) imr         <= cap_data;
      if (ld_ocw2) begin
        ocw2_cmd   <= cap_data[7:5];
        ocw2_level <= cap_data[2:0];
      end
      // OCW3 fields only change when their enable bit is set
      if (ld_ocw3) begin
        if (cap_data[1]) read_isr_sel <= cap_data[0];
        if (cap_data[6]) special_mask <= cap_data[5];
      end
    end
  end

`ifdef SEQ_ERR_EN
  logic err_set;

  // An ICW1 is never an error; what remains with A0=0 has D4=0
  assign err_set = commit & ~is_icw1(cap_a0, cap_data) &
                   (((state_q == UNINIT) & cap_a0) |
                    (((state_q == WAIT_ICW2) | (state_q == WAIT_ICW3) |
                      (state_q == WAIT_ICW4)) & ~cap_a0));

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)   seq_error <= 1'b0;
    else if (ld_icw1) seq_error <= 1'b0;
    else if (err_set) seq_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Scoreboard bench for icw_ocw_sequencer: directed writes queue hand-computed output snapshots,
// a monitor compares them one cycle after each observed write trailing edge.
module tb_icw_ocw_sequencer;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       cs_bar;
  logic       we_bar;
  logic       a0;
  logic [7:0] din;

  logic       init_done;
  logic [4:0] vector_base;
  logic       level_trig;
  logic       single_mode;
  logic [7:0] cascade_cfg;
  logic [4:0] icw4_cfg;
  logic [7:0] imr;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_level;
  logic       read_isr_sel;
  logic       special_mask;
  logic       poll_req;
  logic       seq_err;

  always #5 clk = ~clk;

  icw_ocw_sequencer #(
    .IMR_INIT     (8'h3C),
    .ICW4_DEFAULT (5'h02)
  ) dut (
    .clk             (clk),
    .reset_bar       (reset_bar),
    .chip_select_bar (cs_bar),
    .write_bar       (we_bar),
    .A0              (a0),
    .data_in         (din),
    .init_done       (init_done),
    .vector_base     (vector_base),
    .level_trig      (level_trig),
    .single_mode     (single_mode),
    .cascade_cfg     (cascade_cfg),
    .icw4_cfg        (icw4_cfg),
    .imr             (imr),
    .ocw2_valid      (ocw2_valid),
    .ocw2_cmd        (ocw2_cmd),
    .ocw2_level      (ocw2_level),
    .read_isr_sel    (read_isr_sel),
    .special_mask    (special_mask),
    .poll_req        (poll_req)
`ifdef SEQ_ERR_EN
    ,
    .seq_error       (seq_err)
`endif
  );

`ifndef SEQ_ERR_EN
  assign seq_err = 1'b0;
`endif

  typedef struct packed {
    logic       init_done;
    logic [4:0] vector_base;
    logic       level_trig;
    logic       single_mode;
    logic [7:0] cascade_cfg;
    logic [4:0] icw4_cfg;
    logic [7:0] imr;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       read_isr_sel;
    logic       special_mask;
    logic       poll_req;
    logic       seq_error;
  } obs_t;

  obs_t  e;
  obs_t  exp_q[$];
  string name_q[$];
  obs_t  dir_q[$];
  string dir_name_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    commit_cnt = 0;
  int    handled = 0;
  bit    pulse_chk = 1'b0;
  bit    done_req = 1'b0;

  function automatic obs_t rst_e();
    obs_t o;
    o = '0;
    o.cascade_cfg = 8'h07;
    o.imr         = 8'h3C;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {init_done, vector_base, level_trig, single_mode, cascade_cfg, icw4_cfg, imr,
         ocw2_valid, ocw2_cmd, ocw2_level, read_isr_sel, special_mask, poll_req, seq_err};
    return o;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Bus observer: a write is committed on the first edge it is seen low after being high,
  // unless it was already asserted when reset released.
  logic mon_prev = 1'b0;
  logic mon_blk  = 1'b1;
  always @(posedge clk) begin
    logic w;
    w = !cs_bar && !we_bar;
    if (!reset_bar) begin
      mon_prev = 1'b0;
      mon_blk  = 1'b1;
    end else begin
      if (mon_prev && !w) commit_cnt++;
      if (!w) mon_blk = 1'b0;
      mon_prev = w && !mon_blk;
    end
  end

  always @(negedge clk) begin
    if (pulse_chk) begin
      pulse_chk = 1'b0;
      check("pulse_clear", 64'({ocw2_valid, poll_req}), 64'(0));
    end
    if (handled != commit_cnt) begin
      handled++;
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 64'(1), 64'(0));
      end else begin
        obs_t  ex;
        string nm;
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 64'(sample()), 64'(ex));
        pulse_chk = 1'b1;
      end
    end
    if (dir_q.size() > 0) begin
      obs_t  ex;
      string nm;
      ex = dir_q.pop_front();
      nm = dir_name_q.pop_front();
      check(nm, 64'(sample()), 64'(ex));
    end
    if (done_req) begin
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic direct(input string nm);
    dir_q.push_back(e);
    dir_name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic wr_cmd(input logic a, input logic [7:0] d, input int len, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
    cs_bar = 1'b0; we_bar = 1'b0; a0 = a;
    din = (len == 1) ? d : ~d;
    for (int i = 1; i < len; i++) begin
      @(posedge clk); #1;
      din = (i == len - 1) ? d : ~d;
    end
    @(posedge clk); #1;
    cs_bar = 1'b1; we_bar = 1'b1; a0 = ~a; din = ~d;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_bar = 1'b0; cs_bar = 1'b1; we_bar = 1'b1; a0 = 1'b0; din = 8'h00;
    e = rst_e();
    repeat (2) @(posedge clk);
    #1 direct("reset_held");
    #1 reset_bar = 1'b1;
    @(posedge clk); #1;
    direct("reset_state");

    // UNINIT only accepts ICW1
`ifdef SEQ_ERR_EN
    e.seq_error = 1'b1;
`endif
    wr_cmd(1'b1, 8'hFF, 1, "uninit_a0_1");
    wr_cmd(1'b0, 8'h20, 1, "uninit_ocw");

    e.seq_error = 1'b0; e.single_mode = 1'b1;
    wr_cmd(1'b0, 8'h13, 1, "icw1_a");
    e.vector_base = 5'h04;
    wr_cmd(1'b1, 8'h20, 1, "icw2_a");
    e.icw4_cfg = 5'h01; e.init_done = 1'b1;
    wr_cmd(1'b1, 8'h01, 1, "icw4_a");

    e.init_done = 1'b0; e.single_mode = 1'b0; e.icw4_cfg = 5'h00;
    wr_cmd(1'b0, 8'h11, 1, "icw1_b");
    e.vector_base = 5'h01;
    wr_cmd(1'b1, 8'h08, 1, "icw2_b");
    e.cascade_cfg = 8'h04;
    wr_cmd(1'b1, 8'h04, 1, "icw3_b");
    e.icw4_cfg = 5'h1D; e.init_done = 1'b1;
    wr_cmd(1'b1, 8'h1D, 1, "icw4_b");

    e.imr = 8'hA5;
    wr_cmd(1'b1, 8'hA5, 3, "ocw1_long_pulse");
    e.ocw2_valid = 1'b1; e.ocw2_cmd = 3'b001; e.ocw2_level = 3'd0;
    wr_cmd(1'b0, 8'h20, 1, "ocw2_ns_eoi");
    e.ocw2_cmd = 3'b011; e.ocw2_level = 3'd7;
    wr_cmd(1'b0, 8'h67, 1, "ocw2_sp_eoi");
    e.ocw2_valid = 1'b0;

    e.read_isr_sel = 1'b1;
    wr_cmd(1'b0, 8'h0B, 1, "ocw3_ris");
    e.special_mask = 1'b1;
    wr_cmd(1'b0, 8'h68, 1, "ocw3_smm");
    e.poll_req = 1'b1;
    wr_cmd(1'b0, 8'h0C, 1, "ocw3_poll");
    e.poll_req = 1'b0; e.special_mask = 1'b0; e.read_isr_sel = 1'b0;
    wr_cmd(1'b0, 8'h4A, 1, "ocw3_clear");

    // Write strobe without chip select must not commit
    @(posedge clk); #1;
    we_bar = 1'b0; a0 = 1'b0; din = 8'h13;
    @(posedge clk); #1;
    we_bar = 1'b1;
    @(posedge clk); #1;
    direct("cs_high_ignored");

    e.init_done = 1'b0; e.level_trig = 1'b1; e.single_mode = 1'b1;
    e.imr = 8'h3C; e.cascade_cfg = 8'h07; e.icw4_cfg = 5'h00;
    wr_cmd(1'b0, 8'h1A, 1, "icw1_no_ic4");
    e.vector_base = 5'h1F; e.icw4_cfg = 5'h02; e.init_done = 1'b1;
    wr_cmd(1'b1, 8'hF8, 1, "icw2_ready_default");

    e.init_done = 1'b0; e.level_trig = 1'b0; e.single_mode = 1'b0; e.icw4_cfg = 5'h00;
    wr_cmd(1'b0, 8'h11, 1, "icw1_c");
    e.vector_base = 5'h08;
    wr_cmd(1'b1, 8'h40, 1, "icw2_c");
`ifdef SEQ_ERR_EN
    e.seq_error = 1'b1;
`endif
    wr_cmd(1'b0, 8'h0B, 1, "ocw3_in_wait_icw3");
    e.seq_error = 1'b0; e.single_mode = 1'b1;
    wr_cmd(1'b0, 8'h13, 1, "icw1_restart");
    e.vector_base = 5'h05;
    wr_cmd(1'b1, 8'h28, 1, "icw2_restart");

    wr_cmd(1'b0, 8'h13, 1, "icw1_d");
`ifdef SEQ_ERR_EN
    e.seq_error = 1'b1;
`endif
    wr_cmd(1'b0, 8'h20, 1, "ocw2_in_wait_icw2");
    e.vector_base = 5'h06;
    wr_cmd(1'b1, 8'h30, 1, "icw2_still_waiting");
    e.icw4_cfg = 5'h03; e.init_done = 1'b1;
    wr_cmd(1'b1, 8'h03, 1, "icw4_d");
    e.seq_error = 1'b0; e.init_done = 1'b0; e.icw4_cfg = 5'h00;
    wr_cmd(1'b0, 8'h13, 1, "icw1_clears_err");

    // Reset in the middle of an ICW1 write, strobe held across release
    @(posedge clk); #1;
    cs_bar = 1'b0; we_bar = 1'b0; a0 = 1'b0; din = 8'h13;
    @(posedge clk); #1;
    reset_bar = 1'b0;
    e = rst_e();
    @(posedge clk); #1;
    direct("reset_mid_write");
    #1 reset_bar = 1'b1;
    repeat (2) @(posedge clk);
    #1 cs_bar = 1'b1; we_bar = 1'b1;
    repeat (3) @(posedge clk);
    #1 direct("no_commit_after_reset");

    e.single_mode = 1'b1;
    wr_cmd(1'b0, 8'h13, 1, "icw1_after_reset");

    repeat (3) @(posedge clk);
    #1 done_req = 1'b1;
  end

endmodule
